// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path.
package la_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 11;

    // State codes, 3 bits wide.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRE_FILL  = 3'd1;
    localparam logic [2:0] S_WAIT_TRIG = 3'd2;
    localparam logic [2:0] S_POST_FILL = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_PRE_FILL  = S_PRE_FILL,
        ST_WAIT_TRIG = S_WAIT_TRIG,
        ST_POST_FILL = S_POST_FILL,
        ST_DONE      = S_DONE
    } cap_state_t;

endpackage

// File: rtl/trig_matcher.sv
// Registered masked compare: captures the probe sample and its match flag together.
module trig_matcher
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] probe_in,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic [DATA_WIDTH-1:0] sample_q,
    output logic                  match_q
);

    // Sample and match flag share one register stage so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            match_q  <= 1'b0;
        end else begin
            sample_q <= probe_in;
            match_q  <= (((probe_in ^ pattern) & mask) == '0);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Trigger-driven capture controller feeding a circular sample buffer.
module capture_ctrl
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] probe_in,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_pattern,
    input  logic [ADDR_WIDTH-1:0] pre_trig_len,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    // DEPTH expressed in the widened post-counter width.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    cap_state_t            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [ADDR_WIDTH-1:0] pre_len_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic                  trig_pend;
    logic                  arm_ok;
    logic                  writing;
    logic [DATA_WIDTH-1:0] mask_eff;
    logic [DATA_WIDTH-1:0] pattern_eff;
    logic [DATA_WIDTH-1:0] sample_q;
    logic                  match_q;
    logic [ADDR_WIDTH:0]   post_target;

    assign arm_ok  = arm && !abort && (state == ST_IDLE || state == ST_DONE);
    assign writing = (state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) || (state == ST_POST_FILL);
    // The sample taken on the arm edge is written first, so it must already
    // be compared against the new mask/pattern rather than the stale ones.
    assign mask_eff    = arm_ok ? trig_mask    : mask_q;
    assign pattern_eff = arm_ok ? trig_pattern : pattern_q;
    assign post_target = DEPTH_C - {1'b0, pre_len_q};

    trig_matcher #(.DATA_WIDTH(DATA_WIDTH)) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .probe_in (probe_in),
        .mask     (mask_eff),
        .pattern  (pattern_eff),
        .sample_q (sample_q),
        .match_q  (match_q)
    );

    // Capture FSM with write pointer, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            pre_len_q  <= '0;
            mask_q     <= '0;
            pattern_q  <= '0;
            trig_pend  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            wr_data <= sample_q;
            wr_en   <= writing;
            busy    <= writing;
            if (writing) begin
                wr_addr <= ptr;
                ptr     <= ptr + 1'b1;
            end
            // Status follows one edge after the trigger sample's write cycle,
            // when wr_addr still holds the trigger sample's address.
            if (trig_pend) begin
                trig_pend  <= 1'b0;
                triggered  <= 1'b1;
                trig_addr  <= wr_addr;
                start_addr <= wr_addr - pre_len_q;
            end
            if (abort) begin
                state <= ST_IDLE;
                wr_en <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (state == ST_DONE) done <= 1'b1;
                        if (arm) begin
                            mask_q     <= trig_mask;
                            pattern_q  <= trig_pattern;
                            pre_len_q  <= pre_trig_len;
                            triggered  <= 1'b0;
                            done       <= 1'b0;
                            trig_addr  <= '0;
                            start_addr <= '0;
                            trig_pend  <= 1'b0;
                            ptr        <= '0;
                            pre_cnt    <= '0;
                            post_cnt   <= '0;
                            state      <= (pre_trig_len == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
                        end
                    end
                    ST_PRE_FILL: begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt + 1'b1 == pre_len_q) state <= ST_WAIT_TRIG;
                    end
                    ST_WAIT_TRIG: begin
                        // match_q belongs to the sample being written on this edge.
                        if (match_q) begin
                            post_cnt  <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                            trig_pend <= 1'b1;
                            state     <= (&pre_len_q) ? ST_DONE : ST_POST_FILL;
                        end
                    end
                    ST_POST_FILL: begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt + 1'b1 == post_target) state <= ST_DONE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
